// File: rtl/fir_out_pkg.sv
// rtl/fir_out_pkg.sv - shared widths and sample type for the FIR output FIFO
//   DATA_W : FIR sample width
//   ERR_W  : error sideband width
//   SEL_W  : filter-select width
//   fir_sample_t : {err, data} as stored in the FIFO
package fir_out_pkg;
  localparam int DATA_W = 12;
  localparam int ERR_W  = 2;
  localparam int SEL_W  = 2;

  typedef struct packed {
    logic [ERR_W-1:0]  err;
    logic [DATA_W-1:0] data;
  } fir_sample_t;
endpackage

// File: rtl/fir_output_fifo_if.sv
// rtl/fir_output_fifo_if.sv - sink/source streaming bundle of the FIR output FIFO
//   ast_sink_data/error/valid       : FIR side into the FIFO (no ready)
//   ast_source_data/error/valid     : head of FIFO towards the consumer
//   ast_source_ready                : consumer accepts head when valid & ready
//   modport slave  : FIFO side
//   modport master : producer/consumer side
interface fir_output_fifo_if;
  import fir_out_pkg::*;

  logic [DATA_W-1:0] ast_sink_data;
  logic [ERR_W-1:0]  ast_sink_error;
  logic              ast_sink_valid;
  logic [DATA_W-1:0] ast_source_data;
  logic [ERR_W-1:0]  ast_source_error;
  logic              ast_source_valid;
  logic              ast_source_ready;

  modport slave (
    input  ast_sink_data, ast_sink_error, ast_sink_valid, ast_source_ready,
    output ast_source_data, ast_source_error, ast_source_valid
  );

  modport master (
    output ast_sink_data, ast_sink_error, ast_sink_valid, ast_source_ready,
    input  ast_source_data, ast_source_error, ast_source_valid
  );
endinterface

// File: rtl/fir_out_fifo_mem.sv
// rtl/fir_out_fifo_mem.sv - DEPTH x sample simple dual-port RAM, registered write, async read
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : sample to store
//   i_raddr : read address (head pointer)
//   o_rdata : sample at i_raddr, combinational
module fir_out_fifo_mem
  import fir_out_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  fir_sample_t   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output fir_sample_t   o_rdata
);
  fir_sample_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fir_output_fifo.sv
// rtl/fir_output_fifo.sv - FIR sample FIFO with sel-change flush, settling blanking and overflow flag
//   clk, reset  : clock, synchronous active-high reset
//   sel         : filter select; any change flushes the FIFO and restarts blanking
//   ast         : sink/source stream bundle (fir_output_fifo_if.slave)
//   ovf_clear   : clears overflow (and drop_count)
//   overflow    : sticky, a sample was dropped on a full FIFO
//   fill_level  : current occupancy 0..DEPTH
//   drop_count  : saturating drop counter, only with FIR_OUT_FIFO_STATS_EN defined
module fir_output_fifo
  import fir_out_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int BLANK_SAMPLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         sel,
  fir_output_fifo_if.slave         ast,
  input  logic                     ovf_clear,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill_level
`ifdef FIR_OUT_FIFO_STATS_EN
  ,
  output logic [15:0]              drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (BLANK_SAMPLES > 0) ? $clog2(BLANK_SAMPLES + 1) : 1;

  logic [SEL_W-1:0] r_sel_q;
  logic [BW-1:0]    r_blank_cnt;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_sel_chg;
  logic             w_blanking;
  logic             w_valid;
  logic             w_full;
  logic             w_pop;
  logic             w_accept;
  logic             w_push;
  logic             w_drop;
  fir_sample_t      w_wdata;
  fir_sample_t      w_head;

  // A sel change takes priority over everything: flush, reload blanking,
  // and ignore any write or read happening in the same cycle.
  assign w_sel_chg  = (sel != r_sel_q);
  assign w_blanking = (r_blank_cnt != '0);
  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = w_valid & ast.ast_source_ready & ~w_sel_chg;
  assign w_accept   = ast.ast_sink_valid & ~w_blanking & ~w_sel_chg;
  // A simultaneous pop frees the slot, so a full FIFO can still take a sample.
  assign w_push     = w_accept & (~w_full | w_pop);
  assign w_drop     = w_accept & w_full & ~w_pop;

  assign w_wdata.err  = ast.ast_sink_error;
  assign w_wdata.data = ast.ast_sink_data;

  fir_out_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_q     <= sel;
      r_blank_cnt <= BW'(BLANK_SAMPLES);
    end else begin
      r_sel_q <= sel;
      if (w_sel_chg) begin
        r_blank_cnt <= BW'(BLANK_SAMPLES);
      end else if (ast.ast_sink_valid && w_blanking) begin
        r_blank_cnt <= r_blank_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_sel_chg) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Set wins over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clear) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef FIR_OUT_FIFO_STATS_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_drop) begin
      if (r_drop_count != 16'hFFFF) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end else if (ovf_clear) begin
      r_drop_count <= '0;
    end
  end

  assign drop_count = r_drop_count;
`endif

  // Head is gated by valid so the outputs read 0 while empty (RAM content
  // is never reset).
  assign ast.ast_source_valid = w_valid;
  assign ast.ast_source_data  = w_valid ? w_head.data : '0;
  assign ast.ast_source_error = w_valid ? w_head.err  : '0;
  assign overflow             = r_overflow;
  assign fill_level           = r_count;
endmodule
